// File: rtl/input_double_buffer.sv
// Ping-pong activation store: the loader fills one bank while the array reads the other.
// The banks swap on switch_banks, and write_done flags a complete tile in the write bank.
module input_double_buffer #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int BANK_DEPTH      = 256,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_enable,
  input  logic [COUNTER_WIDTH-1:0]   config_data,
  input  logic                       wen,
  input  logic [BANK_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       ren,
  input  logic [BANK_ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rvalid,
  input  logic                       switch_banks,
  output logic                       write_bank,
  output logic                       write_done
);

  localparam logic [BANK_ADDR_WIDTH:0] DEPTH_LIMIT = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);

  logic [DATA_WIDTH-1:0]    bank_mem [2][BANK_DEPTH];
  logic [COUNTER_WIDTH-1:0] fill_count;
  logic [COUNTER_WIDTH-1:0] write_count;
  logic                     waddr_ok;
  logic                     raddr_ok;
  logic                     read_bank;
  logic                     clear_fill;

  assign waddr_ok   = {1'b0, waddr} < DEPTH_LIMIT;
  assign raddr_ok   = {1'b0, raddr} < DEPTH_LIMIT;
  assign read_bank  = ~write_bank;
  assign clear_fill = switch_banks | config_enable;

  // Memory is never reset; out-of-range writes are dropped so no other word is touched.
  always_ff @(posedge clk) begin
    if (wen && waddr_ok) begin
      bank_mem[write_bank][waddr] <= wdata;
    end
  end

  // Bank selection and fill tracking all use the pre-edge write_bank, so a write or
  // read issued alongside switch_banks still targets the old assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_bank  <= 1'b0;
      fill_count  <= '0;
      write_count <= '0;
      write_done  <= 1'b0;
    end else begin
      if (switch_banks) begin
        write_bank <= ~write_bank;
      end
      if (config_enable) begin
        fill_count <= config_data;
      end
      if (clear_fill) begin
        write_count <= '0;
        write_done  <= 1'b0;
      end else begin
        if (wen && (write_count != fill_count)) begin
          write_count <= write_count + 1'b1;
        end
        if (write_count == fill_count) begin
          write_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (ren) begin
      rvalid <= 1'b1;
      rdata  <= raddr_ok ? bank_mem[read_bank][raddr] : '0;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_double_buffer.sv
// Directed bench for input_double_buffer: table-driven vectors plus hand-written
// sequences for switch collisions, saturation and asynchronous reset.
module tb_input_double_buffer;

  logic        clk;
  logic        rst_n;
  logic        config_enable;
  logic [31:0] config_data;
  logic        wen;
  logic [7:0]  waddr;
  logic [63:0] wdata;
  logic        ren;
  logic [7:0]  raddr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        switch_banks;
  logic        write_bank;
  logic        write_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        cfg_en;
    logic [31:0] cfg_data;
    logic        wen;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic        ren;
    logic [7:0]  raddr;
    logic        sw;
    logic        exp_rvalid;
    logic        chk_rdata;
    logic [63:0] exp_rdata;
    logic        exp_bank;
    logic        exp_done;
  } vec_t;

  vec_t tbl[$];

  input_double_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .config_enable(config_enable),
    .config_data  (config_data),
    .wen          (wen),
    .waddr        (waddr),
    .wdata        (wdata),
    .ren          (ren),
    .raddr        (raddr),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .switch_banks (switch_banks),
    .write_bank   (write_bank),
    .write_done   (write_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic c_en, logic [31:0] c_data, logic w, logic [7:0] wa,
                              logic [63:0] wd, logic r, logic [7:0] ra, logic s,
                              logic e_rv, logic c_rd, logic [63:0] e_rd, logic e_bk,
                              logic e_dn);
    vec_t v;
    v.cfg_en = c_en;  v.cfg_data = c_data;
    v.wen = w;        v.waddr = wa;       v.wdata = wd;
    v.ren = r;        v.raddr = ra;       v.sw = s;
    v.exp_rvalid = e_rv; v.chk_rdata = c_rd; v.exp_rdata = e_rd;
    v.exp_bank = e_bk;   v.exp_done = e_dn;
    return v;
  endfunction

  task automatic check_val(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    config_enable = v.cfg_en;
    config_data   = v.cfg_data;
    wen           = v.wen;
    waddr         = v.waddr;
    wdata         = v.wdata;
    ren           = v.ren;
    raddr         = v.raddr;
    switch_banks  = v.sw;
  endtask

  task automatic checkOutput(string tag, vec_t v);
    check_val({tag, ".rvalid"}, {63'd0, rvalid}, {63'd0, v.exp_rvalid});
    if (v.chk_rdata) check_val({tag, ".rdata"}, rdata, v.exp_rdata);
    check_val({tag, ".write_bank"}, {63'd0, write_bank}, {63'd0, v.exp_bank});
    check_val({tag, ".write_done"}, {63'd0, write_done}, {63'd0, v.exp_done});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string tag, vec_t v);
    applyStimulus(v);
    tick();
    checkOutput(tag, v);
  endtask

  initial begin
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #2;
    check_val("reset.rdata", rdata, 64'd0);
    check_val("reset.rvalid", {63'd0, rvalid}, 64'd0);
    check_val("reset.write_bank", {63'd0, write_bank}, 64'd0);
    check_val("reset.write_done", {63'd0, write_done}, 64'd0);
    #21 rst_n = 1'b1;

    // Tile of 50 words into bank 0; done rises one edge after the 50th write
    step("cfg50", mk(1, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 50; i++) begin
      step($sformatf("fill0[%0d]", i),
           mk(0, 0, 1, 8'(i), 64'(i + 100), 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step("fill0.done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Swap, then read bank 0 while filling bank 1
    tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0,   1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 200, 1, 0, 0, 1, 1, 100, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 201, 1, 1, 0, 1, 1, 101, 1, 0));
    tbl.push_back(mk(0, 0, 1, 2, 202, 1, 2, 0, 1, 1, 102, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3, 203, 1, 5, 0, 1, 1, 105, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4, 204, 0, 0, 0, 0, 1, 105, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl[%0d]", i), tbl[i]);
    end
    for (int i = 5; i < 50; i++) begin
      step($sformatf("fill1[%0d]", i),
           mk(0, 0, 1, 8'(i), 64'(i + 200), 0, 0, 0, 0, 0, 0, 1, 0));
    end
    step("fill1.done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    // Swap back and read what was loaded into bank 1
    step("sw2",     mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0));
    step("rd1[3]",  mk(0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 203, 0, 0));
    step("rd1[0]",  mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 200, 0, 0));

    // Switch with write and read in the same cycle: both use the old banks
    step("cfg1",    mk(1, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0));
    step("sw_coll", mk(0, 0, 1, 7, 'hAA, 1, 7, 1, 1, 1, 207, 1, 0));
    step("coll.idle0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("coll.idle1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("coll.rd0[7]", mk(0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 'hAA, 1, 0));
    step("coll.wr",   mk(0, 0, 1, 10, 'h55, 0, 0, 0, 0, 0, 0, 1, 0));
    step("coll.done", mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 1));

    // Saturation: fill_count=3 with 5 writes into bank 1
    step("cfg3", mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat.wr%0d", i + 1),
           mk(0, 0, 1, 8'(20 + i), 64'(300 + i), 0, 0, 0, 0, 0, 0, 1, (i >= 3) ? 1'b1 : 1'b0));
    end
    step("sat.idle",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step("sat.sw",    mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("sat.after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of a read burst from bank 1
    step("burst[20]", mk(0, 0, 0, 0, 0, 1, 20, 0, 1, 1, 300, 0, 0));
    step("burst[21]", mk(0, 0, 0, 0, 0, 1, 21, 0, 1, 1, 301, 0, 0));
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst.rdata", rdata, 64'd0);
    check_val("midrst.rvalid", {63'd0, rvalid}, 64'd0);
    check_val("midrst.write_bank", {63'd0, write_bank}, 64'd0);
    check_val("midrst.write_done", {63'd0, write_done}, 64'd0);
    #3 rst_n = 1'b1;
    step("post.cfg0", mk(1, 0, 0, 0, 0, 1, 22, 0, 1, 0, 0, 0, 0));
    step("post.done", mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
